logrigs_serial: RTL and testbench
=================================

// Module: logrigs_serial
// PURPOSE
//  Sequential logical right shifter / serializer: the right-shift counterpart of the
//  team's combinational left-shift block. Accepts an (N+1)-bit word via valid/ready,
//  shifts it right one bit per clock for a requested count and emits each shifted-out
//  LSB on ser_out. Pulses done with the final word. Sits between datapath and serial links.
// PARAMETERS
//  N   7   MSB index; data width is N+1 bits (a[N:0] convention)
//  SW  $clog2(N+2)   shamt width (local, derived; not overridable)
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      synchronous, active-high reset
//  load_valid  in   1      load_data/shamt valid
//  load_ready  out  1      block can accept a load (=1 only in IDLE)
//  load_data   in   N+1    word to shift
//  shamt       in   SW     shift count; values >N+1 saturate to N+1
//  hold        in   1      1 = freeze shifting this cycle (SHIFT state only)
//  q           out  N+1    current shift register contents
//  ser_out     out  1      last bit shifted out of q[0]
//  busy        out  1      1 while in SHIFT
//  done        out  1      one-cycle pulse: q holds final result
// BEHAVIOUR
//  - One clock, reset synchronous active-high. Reset: state=IDLE, q=0, ser_out=0,
//    busy=0, done=0, cnt=0. Reset mid-SHIFT aborts; no done pulse follows.
//  - States: IDLE, SHIFT. load_ready = (state==IDLE) && !rst; busy = (state==SHIFT).
//  - Accept = load_valid && load_ready at an edge. At accept: q<=load_data,
//    cnt<=min(shamt,N+1), fill bit latched (0 without macro).
//      shamt==0 -> stay IDLE, done=1 next cycle, q=load_data, ser_out unchanged.
//      shamt>=1 -> go SHIFT, done=0.
//  - SHIFT, each edge with hold=0: q<={fill,q[N:1]}, ser_out<=q[0], cnt<=cnt-1.
//    When cnt==1 at that edge: state<=IDLE, done<=1. hold=1: q, cnt, ser_out frozen.
//  - Latency: accept at edge k with shamt=S>=1, no hold -> done high in cycle after
//    edge k+S; load_ready high in that same cycle (back-to-back loads allowed,
//    next accept may coincide with done cycle).
//  - done is high exactly one cycle; deasserts at next edge regardless of load_valid.
//  - load_valid while busy: ignored, no state change; data not queued.
//  - Saturation: shamt>N+1 behaves exactly as N+1 (q ends all-fill).
//  - q, ser_out hold their values in IDLE.
// CONFIGURATION
//  Macro ARITH_SHIFT_EN:
//   defined     -> extra input port 'arith' (1 bit), sampled at accept. arith=1:
//                  fill = load_data[N] (sign extension, arithmetic right shift);
//                  arith=0: fill=0. Saturated shift of negative word yields all ones.
//   not defined -> no 'arith' port; fill always 0 (pure logical right shift).
// TESTING
//  1 rst=1 two cycles -> q=0, ser_out=0, busy=0, done=0, load_ready=0 during rst, 1 after.
//  2 load 8'b1011_0110, shamt=3, hold=0 -> busy 3 cycles, ser_out seq 0,1,1;
//    done 1 cycle with q=8'b0001_0110, load_ready=1.
//  3 load 8'hA5, shamt=0 -> next cycle done=1, q=8'hA5, busy never asserted.
//  4 load 8'hFF, shamt=10 -> 8 shift cycles (saturated), final q=8'h00, ser_out=1.
//  5 load 8'hF0, shamt=4, hold=1 for 2 cycles mid-shift, new load_valid while busy
//    -> done 6 cycles after accept, q=8'h0F, second load ignored; rst in 2nd
//    shift cycle -> q=0, no done.
//  6 ARITH_SHIFT_EN, arith=1, load 8'h80, shamt=3 -> q=8'hF0;
//    arith=0 same load -> q=8'h10.

Source files
------------

// File: rtl/logrigs_serial_if.sv
// Load/status bundle for the logrigs_serial right shifter.
// The 'arith' signal exists only when ARITH_SHIFT_EN is defined.
interface logrigs_serial_if #(
    parameter int N = 7
);
    localparam int SW = $clog2(N + 2);

    logic          load_valid;
    logic          load_ready;
    logic [N:0]    load_data;
    logic [SW-1:0] shamt;
    logic          hold;
`ifdef ARITH_SHIFT_EN
    logic          arith;
`endif
    logic [N:0]    q;
    logic          ser_out;
    logic          busy;
    logic          done;

    modport master (
        output load_valid, load_data, shamt, hold,
`ifdef ARITH_SHIFT_EN
        output arith,
`endif
        input  load_ready, q, ser_out, busy, done
    );

    modport slave (
        input  load_valid, load_data, shamt, hold,
`ifdef ARITH_SHIFT_EN
        input  arith,
`endif
        output load_ready, q, ser_out, busy, done
    );
endinterface

// File: rtl/logrigs_serial.sv
// Sequential right shifter / serializer: one bit per clock, LSB out on ser_out.
// Macro ARITH_SHIFT_EN adds an 'arith' input selecting sign fill instead of zero fill.
module logrigs_serial #(
    parameter int N = 7
) (
    input  logic             clk,
    input  logic             rst,
    logrigs_serial_if.slave  bus
);
    localparam int SW = $clog2(N + 2);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [N:0]    r_q;
    logic [N:0]    w_q_shr;
    logic [SW-1:0] r_cnt;
    logic [SW-1:0] w_cnt_load;
    logic          r_ser;
    logic          r_done;
    logic          r_fill;
    logic          w_fill;
    logic          w_accept;
    logic          w_shift;
    logic          w_last;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_shr
            assign w_q_shr[gi] = r_q[gi+1];
        end
    endgenerate
    assign w_q_shr[N] = r_fill;

`ifdef ARITH_SHIFT_EN
    assign w_fill = bus.arith & bus.load_data[N];
`else
    assign w_fill = 1'b0;
`endif

    assign bus.load_ready = (r_state == IDLE) && !rst;
    assign bus.busy       = (r_state == SHIFT);
    assign bus.q          = r_q;
    assign bus.ser_out    = r_ser;
    assign bus.done       = r_done;

    always_comb begin
        w_state_next = r_state;
        // Counts beyond the word width saturate: the word ends all-fill either way.
        w_cnt_load   = (bus.shamt > SW'(N + 1)) ? SW'(N + 1) : bus.shamt;
        w_accept     = bus.load_valid && bus.load_ready;
        w_shift      = (r_state == SHIFT) && !bus.hold;
        w_last       = w_shift && (r_cnt == SW'(1));
        case (r_state)
            IDLE:    if (w_accept && (bus.shamt != '0)) w_state_next = SHIFT;
            SHIFT:   if (w_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            r_cnt  <= '0;
            r_ser  <= 1'b0;
            r_done <= 1'b0;
            r_fill <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_q    <= bus.load_data;
                r_cnt  <= w_cnt_load;
                r_fill <= w_fill;
                r_done <= (bus.shamt == '0);
            end else if (w_shift) begin
                r_q    <= w_q_shr;
                r_ser  <= r_q[0];
                r_cnt  <= r_cnt - SW'(1);
                r_done <= w_last;
            end
        end
    end
endmodule

// File: tb/tb_logrigs_serial.sv
// Randomized self-checking bench for logrigs_serial against an arithmetic shift model.
module tb_logrigs_serial;
    localparam int N  = 7;
    localparam int SW = $clog2(N + 2);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logrigs_serial_if #(.N(N)) bus();
    logrigs_serial #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    int   total = 0;
    int   bad   = 0;
    logic exp_ser = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected word after k right shifts; sign fill when arithmetic and negative.
    function automatic logic [N:0] ref_shr(input logic [N:0] d, input int k, input bit ar);
        logic [N:0] ones;
        logic [N:0] r;
        ones = '1;
        r = d >> k;
        if (ar && d[N]) r = r | ~(ones >> k);
        return r;
    endfunction

    task automatic txn(input logic [N:0] d, input logic [SW-1:0] s, input bit ar,
                       input int hold_pct, input logic [15:0] hold_mask,
                       input bit busy_load, input bit gap);
        int sat, shifts, cycles, nhold, budget;
        bit h, ar_eff;
        logic [N:0] exp_final;
`ifdef ARITH_SHIFT_EN
        ar_eff = ar;
`else
        ar_eff = 1'b0;
`endif
        sat = (int'(s) > N + 1) ? N + 1 : int'(s);
        budget = 0;
        while (!bus.load_ready && budget < 20) begin
            tick();
            budget++;
        end
        chk("ready_before_load", bus.load_ready, 1);
        bus.load_valid = 1'b1;
        bus.load_data  = d;
        bus.shamt      = s;
        bus.hold       = 1'b0;
`ifdef ARITH_SHIFT_EN
        bus.arith      = ar;
`endif
        tick();
        if (busy_load && sat != 0) bus.load_data = ~d;
        else bus.load_valid = 1'b0;
        shifts = 0; cycles = 0; nhold = 0;
        if (sat != 0) begin
            while (shifts < sat && cycles < 64) begin
                chk("busy_mid", bus.busy, 1);
                chk("done_mid", bus.done, 0);
                chk("ready_mid", bus.load_ready, 0);
                chk("q_mid", bus.q, ref_shr(d, shifts, ar_eff));
                chk("ser_mid", bus.ser_out, exp_ser);
                h = (hold_mask != 0) ? hold_mask[cycles % 16] : ($urandom_range(99) < hold_pct);
                bus.hold = h;
                tick();
                cycles++;
                if (h) nhold++;
                else begin
                    shifts++;
                    exp_ser = d[shifts-1];
                end
            end
            bus.hold = 1'b0;
            bus.load_valid = 1'b0;
            chk("latency", cycles, sat + nhold);
        end
        exp_final = ref_shr(d, sat, ar_eff);
        chk("done_pulse", bus.done, 1);
        chk("busy_at_done", bus.busy, 0);
        chk("ready_at_done", bus.load_ready, 1);
        chk("q_final", bus.q, exp_final);
        chk("ser_final", bus.ser_out, exp_ser);
        $display("txn d=%h shamt=%0d arith=%0b holds=%0d q=%h ser=%0b",
                 d, s, ar_eff, nhold, bus.q, bus.ser_out);
        if (gap) begin
            tick();
            chk("done_one_cycle", bus.done, 0);
            chk("q_idle_hold", bus.q, exp_final);
            chk("ser_idle_hold", bus.ser_out, exp_ser);
            chk("busy_idle", bus.busy, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.shamt      = '0;
        bus.hold       = 1'b0;
`ifdef ARITH_SHIFT_EN
        bus.arith      = 1'b0;
`endif
        // Reset held two cycles
        rst = 1'b1;
        tick();
        tick();
        chk("rst_ready", bus.load_ready, 0);
        chk("rst_q", bus.q, 0);
        chk("rst_ser", bus.ser_out, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", bus.load_ready, 1);
        tick();

        // Directed cases
        txn(8'b1011_0110, 4'd3, 1'b0, 0, 16'h0, 1'b0, 1'b1);
        txn(8'hA5, 4'd0, 1'b0, 0, 16'h0, 1'b0, 1'b1);
        txn(8'hFF, 4'd10, 1'b0, 0, 16'h0, 1'b0, 1'b1);
        txn(8'hF0, 4'd4, 1'b0, 0, 16'h0006, 1'b1, 1'b1);
`ifdef ARITH_SHIFT_EN
        txn(8'h80, 4'd3, 1'b1, 0, 16'h0, 1'b0, 1'b1);
        txn(8'h80, 4'd3, 1'b0, 0, 16'h0, 1'b0, 1'b1);
        txn(8'h9C, 4'd12, 1'b1, 0, 16'h0, 1'b0, 1'b1);
`endif

        // Reset during the second shift cycle aborts without done
        bus.load_valid = 1'b1;
        bus.load_data  = 8'hF0;
        bus.shamt      = 4'd4;
        tick();
        bus.load_valid = 1'b0;
        chk("abort_busy", bus.busy, 1);
        tick();
        rst = 1'b1;
        #1;
        chk("abort_ready_in_rst", bus.load_ready, 0);
        tick();
        rst = 1'b0;
        exp_ser = 1'b0;
        chk("abort_q", bus.q, 0);
        chk("abort_ser", bus.ser_out, 0);
        chk("abort_busy_after", bus.busy, 0);
        for (int i = 0; i < 5; i++) begin
            chk("abort_no_done", bus.done, 0);
            tick();
        end
        $display("txn reset-abort q=%h busy=%0b", bus.q, bus.busy);

        // Randomized traffic, including back-to-back loads and holds
        for (int i = 0; i < 40; i++) begin
            txn(N'($urandom) | 8'h00, SW'($urandom_range(0, 15)), 1'($urandom),
                30, 16'h0, 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
